// File: rtl/addsub_cla_pipe.sv
// addsub_cla_pipe: pipelined CLA adder/subtractor, one SEG-bit segment per stage, valid/ready on both sides.
// Define ADDSUB_SAT_EN to clamp overflowing results when sat is set.
module addsub_cla_pipe #(
    parameter int W   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         c,
    output logic         v,
    output logic         z,
    output logic         n
);
    localparam int NSEG = W / SEG;

    logic [NSEG:0]   rdy;
    logic [NSEG-1:0] vld, rc, rs;
    logic [W-1:0]    ra [NSEG];
    logic [W-1:0]    rb [NSEG];
    logic [W-1:0]    rr [NSEG];
    logic            rw, rz;

    function automatic logic [SEG:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
        logic [SEG:0] cv;
        cv[0] = ci;
        for (int i = 0; i < SEG; i++) cv[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & cv[i]);
        return cv;
    endfunction

    assign rdy[NSEG]  = out_ready;
    assign in_ready   = rdy[0];
    assign out_valid  = vld[NSEG-1];
    assign s          = rr[NSEG-1];
    assign c          = rc[NSEG-1];
    assign v          = rc[NSEG-1] ^ rw;
    assign z          = rz;
    assign n          = rr[NSEG-1][W-1];

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_stg
        logic [W-1:0] pa, pb, pr, nr, ns;
        logic         pc, ps, pv;
        logic [SEG:0] cv;
        if (k == 0) begin : g_first
            assign pa = a;
            assign pb = b ^ {W{m}};
            assign pr = '0;
            assign pc = m;
            assign ps = sat;
            assign pv = in_valid;
        end else begin : g_next
            assign pa = ra[k-1];
            assign pb = rb[k-1];
            assign pr = rr[k-1];
            assign pc = rc[k-1];
            assign ps = rs[k-1];
            assign pv = vld[k-1];
        end
        assign rdy[k] = !vld[k] || rdy[k+1];
        assign cv     = cla(pa[k*SEG +: SEG], pb[k*SEG +: SEG], pc);
        assign nr     = pr | (W'(pa[k*SEG +: SEG] ^ pb[k*SEG +: SEG] ^ cv[SEG-1:0]) << (k*SEG));
        if (k == NSEG - 1) begin : g_last
            logic unused_sat;
`ifdef ADDSUB_SAT_EN
            assign ns = (ps && (cv[SEG] ^ cv[SEG-1])) ?
                        (nr[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}}) : nr;
`else
            assign ns = nr;
`endif
            assign unused_sat = rs[k] ^ ps;
            // carry into bit W-1 and zero flag only matter once the whole word is known
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rw <= 1'b0;
                    rz <= 1'b0;
                end else if (rdy[k] && pv) begin
                    rw <= cv[SEG-1];
                    rz <= (ns == '0);
                end
            end
        end else begin : g_mid
            assign ns = nr;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[k] <= 1'b0;
                ra[k]  <= '0;
                rb[k]  <= '0;
                rr[k]  <= '0;
                rc[k]  <= 1'b0;
                rs[k]  <= 1'b0;
            end else if (rdy[k]) begin
                vld[k] <= pv;
                if (pv) begin
                    ra[k] <= pa;
                    rb[k] <= pb;
                    rr[k] <= ns;
                    rc[k] <= cv[SEG];
                    rs[k] <= ps;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_cla_pipe.sv
// tb_addsub_cla_pipe: directed vector table plus stream, backpressure and reset sequences.
module tb_addsub_cla_pipe;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, m = 1'b0, sat = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, c, v, z, n;
    logic [W-1:0] s;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
    logic [16:0] q[$];

    always #5 clk = ~clk;

    addsub_cla_pipe #(.W(16), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c(c), .v(v), .z(z), .n(n)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        m, sat;
        logic [15:0] s;
        logic        c, v, z, n;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic mm);
        return mm ? {1'b0, x} + {1'b0, ~y} + 17'd1 : {1'b0, x} + {1'b0, y};
    endfunction

    // one handshake cycle: drive at negedge, settle, score both interfaces, then wait for the edge
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic im, input logic ordy, output logic acc);
        logic [16:0] e;
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; m = im; sat = 1'b0; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                check("stream_s", {16'h0, s}, {16'h0, e[15:0]});
                check("stream_c", {31'h0, c}, {31'h0, e[16]});
            end
            pops++;
            last_pop = cyc;
            if (pops == 1) first_pop = cyc;
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(ref_op(ia, ib, im));
        cyc++;
    endtask

    initial begin
        logic        acc;
        logic [15:0] hold_s;
        logic        prev_stall;
        int          lat, sent, vcnt;

        vt[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
        vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

        #12;
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_s", {16'h0, s}, 32'd0);
        check("rst_flags", {28'h0, c, v, z, n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = vt[i].a; b = vt[i].b; m = vt[i].m; sat = vt[i].sat; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", i), lat, 32'd4);
            check($sformatf("v%0d_s", i), {16'h0, s}, {16'h0, vt[i].s});
            check($sformatf("v%0d_c", i), {31'h0, c}, {31'h0, vt[i].c});
            check($sformatf("v%0d_v", i), {31'h0, v}, {31'h0, vt[i].v});
            check($sformatf("v%0d_z", i), {31'h0, z}, {31'h0, vt[i].z});
            check($sformatf("v%0d_n", i), {31'h0, n}, {31'h0, vt[i].n});
        end

        // 8 back-to-back beats at full throughput
        @(negedge clk);
        q.delete(); pops = 0; cyc = 0;
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'h1357 * 16'(i + 1), 16'hA5A5 ^ (16'h0F0F * 16'(i)), i[0], 1'b1, acc);
        for (int i = 0; i < 12 && pops < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("stream8_count", pops, 32'd8);
        check("stream8_consecutive", last_pop - first_pop, 32'd7);

        // backpressure: 6 stalled cycles in the middle of a 12-beat stream
        q.delete(); pops = 0; cyc = 0; sent = 0; prev_stall = 1'b0; hold_s = '0;
        for (int i = 0; i < 100 && (sent < 12 || q.size() != 0); i++) begin
            step(sent < 12, 16'h2468 + 16'(sent * 16'h1111), 16'h0F1E * 16'(sent + 3),
                 sent[1], !(i >= 4 && i < 10), acc);
            if (acc) sent++;
            if (!out_ready && out_valid) begin
                if (prev_stall) check("stall_hold_s", {16'h0, s}, {16'h0, hold_s});
                hold_s = s;
                prev_stall = 1'b1;
            end else prev_stall = 1'b0;
            if (i == 9) begin
                check("stall_in_ready", {31'h0, in_ready}, 32'd0);
                check("stall_held", q.size(), 32'd4);
            end
        end
        check("bp_all_out", pops, 32'd12);
        check("bp_queue_empty", q.size(), 32'd0);

        // reset with 3 beats in flight
        q.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 16'h4000 + 16'(i), 16'h0101, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        check("pre_rst_valid", {31'h0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'd0);
        check("async_rst_s", {16'h0, s}, 32'd0);
        check("async_rst_flags", {28'h0, c, v, z, n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b0;
            if (out_valid) vcnt++;
        end
        check("no_stale_after_rst", vcnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
